// File: rtl/psum_collector.sv
// psum_collector: one circular FIFO per array column; rows are popped
// across all columns at once into a registered output.
// Optional feature: define PSUM_COLLECTOR_OVF_EN to add the sticky
// per-column overflow flag output ovf_err.
//
// Handshake: each column accepts a write when wr[c]=1 and that column is
// not full; a row pop is accepted when rd=1 and o_valid=1 (every column
// non-empty). o_ready is the inverse of o_full. All decisions use pre-edge
// state, and out updates one cycle after an accepted pop.
module psum_collector #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready
`ifdef PSUM_COLLECTOR_OVF_EN
    ,
    output logic [col-1:0]         ovf_err
`endif
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

    logic [psum_bw-1:0] mem [col][depth];
    logic [aw-1:0]      wp  [col];
    logic [aw-1:0]      rp  [col];
    logic [cw-1:0]      cnt [col];

    logic [col-1:0] nonempty;
    logic [col-1:0] full;
    logic [col-1:0] wr_ok;
    logic           pop;

    // Per-column status and write acceptance from pre-edge counts.
    always_comb begin
        nonempty = '0;
        full     = '0;
        wr_ok    = '0;
        for (int c = 0; c < col; c++) begin
            nonempty[c] = (cnt[c] != '0);
            full[c]     = (cnt[c] == cw'(depth));
            wr_ok[c]    = wr[c] & ~full[c] & ~reset;
        end
    end

    // Status is forced to its idle values while reset is held so that the
    // flags are correct even before the first reset edge has cleared counts.
    assign o_valid = ~reset & (&nonempty);
    assign o_full  = ~reset & (|full);
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    // Pointers, counts and the registered output row.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                wp[c]  <= '0;
                rp[c]  <= '0;
                cnt[c] <= '0;
            end
            out <= '0;
        end else begin
            for (int c = 0; c < col; c++) begin
                if (wr_ok[c]) wp[c] <= wp[c] + aw'(1);
                if (pop) begin
                    rp[c] <= rp[c] + aw'(1);
                    out[c*psum_bw +: psum_bw] <= mem[c][rp[c]];
                end
                case ({wr_ok[c], pop})
                    2'b10:   cnt[c] <= cnt[c] + cw'(1);
                    2'b01:   cnt[c] <= cnt[c] - cw'(1);
                    default: cnt[c] <= cnt[c];
                endcase
            end
        end
    end

    // Storage array; contents need no reset because counts gate all reads.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (wr_ok[c]) mem[c][wp[c]] <= in[c*psum_bw +: psum_bw];
        end
    end

`ifdef PSUM_COLLECTOR_OVF_EN
    // Sticky record of writes dropped because the column was full.
    always_ff @(posedge clk) begin
        if (reset) ovf_err <= '0;
        else       ovf_err <= ovf_err | (wr & full);
    end
`endif

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed and random stimulus for psum_collector,
// checked against per-column reference queues.
module tb_psum_collector;

    localparam int COLS = 8;
    localparam int BW   = 16;
    localparam int DEP  = 16;
    localparam int W    = COLS * BW;

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    in;
    logic [COLS-1:0] wr;
    logic            rd;
    logic [W-1:0]    out;
    logic            o_valid;
    logic            o_full;
    logic            o_ready;
`ifdef PSUM_COLLECTOR_OVF_EN
    logic [COLS-1:0] ovf_err;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: one queue of pending entries per column.
    logic [BW-1:0]   mq [COLS][$];
    logic [W-1:0]    exp_out;
    logic [COLS-1:0] exp_ovf;

    psum_collector #(.col(COLS), .psum_bw(BW), .depth(DEP)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready)
`ifdef PSUM_COLLECTOR_OVF_EN
        ,
        .ovf_err (ovf_err)
`endif
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus: check flags before the edge, advance the
    // model at the edge, then check registered outputs after it.
    task automatic step(input logic r, input logic [COLS-1:0] w, input logic rdv,
                        input logic [W-1:0] d);
        logic            v;
        logic            f;
        logic [COLS-1:0] fullv;
        reset = r;
        wr    = w;
        rd    = rdv;
        in    = d;
        #1;
        v = 1'b1;
        f = 1'b0;
        fullv = '0;
        for (int c = 0; c < COLS; c++) begin
            if (mq[c].size() == 0) v = 1'b0;
            if (mq[c].size() == DEP) begin
                f = 1'b1;
                fullv[c] = 1'b1;
            end
        end
        if (r) begin
            v = 1'b0;
            f = 1'b0;
        end
        chk("o_valid", W'(o_valid), W'(v));
        chk("o_full",  W'(o_full),  W'(f));
        chk("o_ready", W'(o_ready), W'(!f));
        @(posedge clk);
        if (r) begin
            for (int c = 0; c < COLS; c++) mq[c].delete();
            exp_out = '0;
            exp_ovf = '0;
        end else begin
            if (rdv && v) begin
                for (int c = 0; c < COLS; c++) exp_out[c*BW +: BW] = mq[c].pop_front();
            end
            for (int c = 0; c < COLS; c++) begin
                if (w[c]) begin
                    if (fullv[c]) exp_ovf[c] = 1'b1;
                    else mq[c].push_back(d[c*BW +: BW]);
                end
            end
        end
        #1;
        chk("out", out, exp_out);
`ifdef PSUM_COLLECTOR_OVF_EN
        chk("ovf_err", W'(ovf_err), W'(exp_ovf));
`endif
    endtask

    function automatic logic [W-1:0] rnd_row();
        logic [W-1:0] d;
        for (int c = 0; c < COLS; c++) d[c*BW +: BW] = BW'($urandom);
        return d;
    endfunction

    function automatic logic [W-1:0] same_row(input logic [BW-1:0] x);
        logic [W-1:0] d;
        for (int c = 0; c < COLS; c++) d[c*BW +: BW] = x;
        return d;
    endfunction

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] stag_row;
        exp_out = '0;
        exp_ovf = '0;

        // Reset with active strobes; strobes must be ignored.
        step(1'b1, 8'hFF, 1'b1, rnd_row());
        step(1'b1, 8'hFF, 1'b1, rnd_row());
        chk("reset_out", out, '0);
        // Idle after reset.
        step(1'b0, 8'h00, 1'b0, rnd_row());
        step(1'b0, 8'h00, 1'b1, rnd_row());

        // Staggered fill: one column per cycle, valid only after the last.
        for (int c = 0; c < COLS; c++) begin
            d = rnd_row();
            d[c*BW +: BW] = BW'(16'h0011 * (c + 1));
            step(1'b0, COLS'(1 << c), 1'b0, d);
        end
        step(1'b0, 8'h00, 1'b1, rnd_row());
        stag_row = 128'h0088_0077_0066_0055_0044_0033_0022_0011;
        chk("stagger_row", out, stag_row);
        chk("stagger_empty", W'(o_valid), '0);

        // Fill to full plus one dropped write, then drain.
        step(1'b1, 8'h00, 1'b0, '0);
        for (int k = 1; k <= 17; k++) step(1'b0, 8'hFF, 1'b0, same_row(BW'(k)));
        chk("full_flag", W'(o_full), W'(1));
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 8'h00, 1'b1, rnd_row());
            chk("drain_val", out, same_row(BW'(k)));
        end
`ifdef PSUM_COLLECTOR_OVF_EN
        chk("ovf_all", W'(ovf_err), W'(8'hFF));
`endif

        // Wrap-around: prime one row, then simultaneous write and pop.
        step(1'b1, 8'h00, 1'b0, '0);
        step(1'b0, 8'hFF, 1'b0, rnd_row());
        for (int k = 0; k < 40; k++) step(1'b0, 8'hFF, 1'b1, rnd_row());
        for (int c = 0; c < COLS; c++) chk("wrap_count", W'(mq[c].size()), W'(1));

        // Column 3 empty: rd ignored, then writing column 3 enables a pop.
        step(1'b1, 8'h00, 1'b0, '0);
        step(1'b0, 8'hF7, 1'b0, rnd_row());
        step(1'b0, 8'hF7, 1'b0, rnd_row());
        step(1'b0, 8'h00, 1'b1, rnd_row());
        chk("col3_hold", out, '0);
        step(1'b0, 8'h08, 1'b1, rnd_row());
        step(1'b0, 8'h00, 1'b1, rnd_row());

        // Reset with five rows queued (and an overflow recorded).
        for (int k = 0; k < 20; k++) step(1'b0, 8'hFF, 1'b0, rnd_row());
        for (int k = 0; k < 16; k++) step(1'b0, 8'h00, k < 11, rnd_row());
        step(1'b1, 8'hFF, 1'b1, rnd_row());
        chk("rst_out", out, '0);
        step(1'b0, 8'h00, 1'b1, rnd_row());

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) == 0, COLS'($urandom),
                 $urandom_range(0, 2) != 0, rnd_row());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 The module SHALL have parameter col, default 8: number of array columns, one FIFO each.
REQ-002 The module SHALL have parameter psum_bw, default 16: partial-sum width per column.
REQ-003 The module SHALL have parameter depth, default 16: entries per column FIFO, a power of 2 and at least 2.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port in  input  psum_bw*col: psums from the MAC array south edge; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-007 Port wr  input  col: per-column write strobe, driven by the array's per-column valid.
REQ-008 Port rd  input  1: request to pop one row, meaning one entry from every column.
REQ-009 Port out  output  psum_bw*col: registered popped row, with the same column packing as in.
REQ-010 Port o_valid  output  1: high when every column FIFO is non-empty.
REQ-011 Port o_full  output  1: high when any column FIFO is full.
REQ-012 Port o_ready  output  1: high when no column FIFO is full, i.e. the inverse of o_full.

Function
REQ-013 Each column SHALL keep an independent circular buffer of depth entries, with a write pointer, a read pointer and an occupancy count from 0 to depth.
REQ-014 Column c SHALL store in slice c and advance its write pointer when wr[c]=1 and its count < depth at the clock edge.
REQ-015 A write to a full column SHALL be dropped, leaving the pointer, count and contents unchanged; other columns written in the same cycle are unaffected.
REQ-016 A read SHALL be accepted only when rd=1 and o_valid=1; rd while o_valid=0 is ignored and out holds its value.
REQ-017 On an accepted read, every column SHALL advance its read pointer, and out SHALL take the head entries one cycle later (latency 1).
REQ-018 out SHALL hold its last value in all cycles without an accepted read.
REQ-019 o_valid, o_full and o_ready SHALL be combinational from the current counts, i.e. state before the edge.
REQ-020 Simultaneous read and write on one column SHALL leave its count unchanged; the full and empty checks use pre-edge state.
- A write to a full column is dropped even if the same edge pops it.
- A write to an empty column does not enable a read in the same cycle.
REQ-021 Pointers SHALL wrap modulo depth; after depth writes and depth reads the FIFO is empty with data intact and in order.
REQ-022 Column data SHALL never be reordered, and entries of row k across columns SHALL pop together even if the columns were written in different cycles.

Reset
REQ-023 While reset=1, all pointers and counts SHALL clear to 0 and out SHALL be 0.
REQ-024 While reset=1, o_valid SHALL be 0, o_full SHALL be 0 and o_ready SHALL be 1; stored contents are discarded.
REQ-025 While reset=1, wr and rd SHALL be ignored, and reset asserted mid-stream SHALL discard all pending data.

Configuration
REQ-026 With macro PSUM_COLLECTOR_OVF_EN defined, the module SHALL add output port ovf_err, width col.
- ovf_err[c] is sticky, set on a dropped write to column c.
- ovf_err[c] is cleared only by reset.
- ovf_err[c] is registered, so it is visible in the cycle after the drop.
REQ-027 Without PSUM_COLLECTOR_OVF_EN, port ovf_err SHALL be absent and dropped writes SHALL be silent; all other behaviour is identical.

Verification
REQ-028 Reset then idle -> o_valid=0, o_full=0, o_ready=1, out=0.
REQ-029 Staggered fill, col=8: wr=8'h01 with in slice0=0x0011, then 8'h02 with slice1=0x0022, ..., then 8'h80 with slice7=0x0088; o_valid rises only after the 8th write; rd=1 -> next cycle out = {0x0088,...,0x0011}, o_valid=0.
REQ-030 Full and overflow: write 17 times with wr=8'hFF and values 1..17, depth=16 -> o_full=1 after the 16th write, the 17th is dropped, 16 reads return 1..16, and with OVF_EN ovf_err=8'hFF.
REQ-031 Wrap-around: 40 cycles of simultaneous wr=8'hFF and rd=1 after priming 1 row -> counts stay at 1 and out sequence equals the input sequence delayed by one row.
REQ-032 rd with column 3 empty and the others holding 2 entries -> no pop, out unchanged; writing column 3 makes o_valid=1 the next cycle.
REQ-033 Reset asserted with 5 rows queued -> next cycle counts are 0, o_valid=0, out=0, ovf_err=0.
